// File: rtl/tpm_mux_pkg.sv
// Shared definitions for the 32-channel analog mux front end.
// The logical<->physical address mapping lives here. The remap and demap
// directions are defined side by side so that they cannot drift apart.
package tpm_mux_pkg;

  localparam int NUM_CH = 32;
  localparam int ADDR_W = 5;
  localparam int HALF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // Logical channel -> physical mux address.
  // Channels 0..15 sit on the upper bank. Channels 16..31 are wired in reverse on the lower bank.
  function automatic logic [ADDR_W-1:0] remap(input logic [ADDR_W-1:0] chan);
    if (chan < ADDR_W'(HALF)) remap = chan + ADDR_W'(HALF);
    else                      remap = ADDR_W'(NUM_CH - 1) - chan;
  endfunction

  // Physical mux address -> logical channel (inverse of remap).
  function automatic logic [ADDR_W-1:0] demap(input logic [ADDR_W-1:0] addr);
    if (addr >= ADDR_W'(HALF)) demap = addr - ADDR_W'(HALF);
    else                       demap = ADDR_W'(NUM_CH - 1) - addr;
  endfunction

endpackage

// File: rtl/mux_addr_demap.sv
// Combinational translation of the physical mux address to the logical channel index.
// This is a separate module so that the mapping can be exercised on its own.
module mux_addr_demap
  import tpm_mux_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] chan
);

  assign chan = demap(addr);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for the 32-channel analog mux front end.
// For each physical address it steps A, waits for the analog path to settle, and strobes one ADC conversion.
// It then hands the result downstream, tagged with the logical channel index.
// Once a sample is presented, A is frozen until the sample is accepted. Downstream backpressure therefore never
// causes a sample to be lost or mislabelled.
module mux_scan_sequencer
  import tpm_mux_pkg::*;
#(
  parameter int ADC_W         = 12,
  parameter int SETTLE_CYCLES = 8,
  parameter int ADC_TIMEOUT   = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  output logic [ADDR_W-1:0] A,
  output logic              CS2,
  output logic              CS3,
  output logic              CS4,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [ADC_W-1:0]  adc_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [ADC_W-1:0]  sample_data,
  output logic [ADDR_W-1:0] sample_chan,
  output logic              frame_done,
  output logic              busy,
  output logic              adc_err
);

  // Each counter only has to hold its reload value, which is one less than the programmed cycle count.
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMO_W    = (ADC_TIMEOUT > 1)   ? $clog2(ADC_TIMEOUT)   : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]    TMO_LOAD    = TMO_W'(ADC_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR   = ADDR_W'(NUM_CH - 1);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [ADDR_W-1:0]   addr_chan;
  logic                advance;

  // All three bank chip selects stay asserted (active low) for the whole scan.
  assign CS2  = 1'b0;
  assign CS3  = 1'b0;
  assign CS4  = 1'b0;
  assign busy = (state != ST_IDLE);

  mux_addr_demap u_demap (
    .addr (A),
    .chan (addr_chan)
  );

  // Leave the current address: either its sample was accepted, or the ADC timed out on it.
  // A conversion result that arrives in the expiry cycle wins over the timeout.
  always_comb begin
    // NOTE: assign every always_comb output at the top so that no path leaves it unassigned, which would infer a latch.
    advance = 1'b0;
    if (state == ST_CONVERT && !adc_done && tmo_cnt == '0) advance = 1'b1;
    if (state == ST_HOLD && sample_ready)                  advance = 1'b1;
  end

  // Scan FSM: settle, convert, hold the sample, then move to the next address or stop.
  // NOTE: registered state uses non-blocking assignments so that every right-hand side sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      A            <= '0;
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
      adc_start    <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_chan  <= '0;
      frame_done   <= 1'b0;
      adc_err      <= 1'b0;
    end else begin
      adc_start  <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            A          <= '0;
            settle_cnt <= SETTLE_LOAD;
            adc_err    <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            adc_start <= 1'b1;
            tmo_cnt   <= TMO_LOAD;
            state     <= ST_CONVERT;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_CONVERT: begin
          if (adc_done) begin
            sample_data  <= adc_data;
            sample_chan  <= addr_chan;
            sample_valid <= 1'b1;
            state        <= ST_HOLD;
          end else if (tmo_cnt == '0) begin
            adc_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (sample_ready) sample_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // The advance rules are shared by an accepted sample and a timed-out conversion.
      // These assignments deliberately override the state update made in the case statement above.
      if (advance) begin
        if (A == LAST_ADDR) begin
          frame_done <= 1'b1;
          if (continuous && !stop) begin
            A          <= '0;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end else begin
            state <= ST_IDLE;
          end
        end else if (stop) begin
          state <= ST_IDLE;
        end else begin
          A          <= A + 1'b1;
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_SETTLE;
        end
      end
    end
  end

endmodule
